// File: rtl/cordic_angle_prep.sv
// Angle pre-reduction for the rotation-mode CORDIC: folds any degrees x 100 angle
// into [-9000, 9000] and negates the vector whenever a 180 degree fold is applied.
module cordic_angle_prep #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x_in,
    input  logic signed [W-1:0] y_in,
    input  logic signed [W-1:0] angle_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] x_out,
    output logic signed [W-1:0] y_out,
    output logic signed [W-1:0] angle_out,
    output logic                flip_out
);

    typedef enum logic [1:0] {IDLE, WRAP, FOLD, HOLD} state_t;

    // Angle arithmetic runs one bit wider so +/-36000 is representable.
    localparam logic signed [W:0] A360 = (W+1)'(36000);
    localparam logic signed [W:0] A180 = (W+1)'(18000);
    localparam logic signed [W:0] N180 = -(W+1)'(18000);
    localparam logic signed [W:0] A90  = (W+1)'(9000);
    localparam logic signed [W:0] N90  = -(W+1)'(9000);

    state_t              state_q, state_d;
    logic signed [W-1:0] x_q, x_d, y_q, y_d;
    logic signed [W:0]   a_q, a_d;
    logic signed [W-1:0] xo_q, xo_d, yo_q, yo_d, ao_q, ao_d;
    logic                fo_q, fo_d;

    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] v);
        logic signed [W-1:0] most_neg;
        most_neg = {1'b1, {(W-1){1'b0}}};
        if (v == most_neg) begin
            return ~v;
        end
        return -v;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        a_d     = a_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        ao_d    = ao_q;
        fo_d    = fo_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    a_d     = {angle_in[W-1], angle_in};
                    state_d = WRAP;
                end
            end
            WRAP: begin
                if (a_q >= A180) begin
                    a_d = a_q - A360;
                end else if (a_q < N180) begin
                    a_d = a_q + A360;
                end
                state_d = FOLD;
            end
            FOLD: begin
                // Output registers load only here, so they stay put in every other state.
                if (a_q > A90) begin
                    ao_d = W'(a_q - A180);
                    xo_d = sat_neg(x_q);
                    yo_d = sat_neg(y_q);
                    fo_d = 1'b1;
                end else if (a_q < N90) begin
                    ao_d = W'(a_q + A180);
                    xo_d = sat_neg(x_q);
                    yo_d = sat_neg(y_q);
                    fo_d = 1'b1;
                end else begin
                    ao_d = W'(a_q);
                    xo_d = x_q;
                    yo_d = y_q;
                    fo_d = 1'b0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            a_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            ao_q    <= '0;
            fo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            a_q     <= a_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            ao_q    <= ao_d;
            fo_q    <= fo_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign x_out     = xo_q;
    assign y_out     = yo_q;
    assign angle_out = ao_q;
    assign flip_out  = fo_q;

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Scoreboard bench for cordic_angle_prep: expected results come from an
// independent modulo-based model and are compared as the DUT hands them over.
module tb_cordic_angle_prep;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] x_in = '0, y_in = '0, angle_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] x_out, y_out, angle_out;
    logic                flip_out;

    cordic_angle_prep #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .angle_in(angle_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .angle_out(angle_out), .flip_out(flip_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int a;
        int f;
        int t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_xfer   = 0;
    bit   ov_prev  = 1'b0;
    bit   xfer_prev = 1'b0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    endtask

    function automatic int sneg(input int v);
        return (v == -32768) ? 32767 : -v;
    endfunction

    function automatic exp_t model(input int x, input int y, input int a);
        exp_t r;
        int   t;
        t = (a + 18000) % 36000;
        if (t < 0) t += 36000;
        t = t - 18000;
        r.t0 = 0;
        if (t > 9000 || t < -9000) begin
            r.a = (t > 0) ? t - 18000 : t + 18000;
            r.x = sneg(x);
            r.y = sneg(y);
            r.f = 1;
        end else begin
            r.a = t;
            r.x = x;
            r.y = y;
            r.f = 0;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            check("excl", int'(out_valid && in_ready), 0);
            if (xfer_prev) check("ov_1cyc", int'(out_valid), 0);
            if (out_valid && !ov_prev && sb.size() > 0)
                check("latency", cyc - sb[0].t0, 3);
            xfer_prev = out_valid && out_ready;
            if (out_valid && out_ready) begin
                n_xfer++;
                check("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    mon_e = sb.pop_front();
                    $display("xfer x=%0d y=%0d a=%0d f=%0d (exp %0d %0d %0d %0d)",
                             x_out, y_out, angle_out, flip_out,
                             mon_e.x, mon_e.y, mon_e.a, mon_e.f);
                    check("x_out", int'(x_out), mon_e.x);
                    check("y_out", int'(y_out), mon_e.y);
                    check("angle_out", int'(angle_out), mon_e.a);
                    check("flip_out", int'(flip_out), mon_e.f);
                end
            end
            ov_prev = out_valid;
        end else begin
            ov_prev   = 1'b0;
            xfer_prev = 1'b0;
        end
    end

    task automatic send(input int x, input int y, input int a);
        bit   accepted;
        exp_t e;
        accepted = 1'b0;
        @(posedge clk);
        #1;
        x_in     = W'(x);
        y_in     = W'(y);
        angle_in = W'(a);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e    = model(x, y, a);
                e.t0 = cyc;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        check("accept", int'(accepted), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    int tx[10] = '{300, 100, 200, 11, -12, 13, -14, 15, -16, -32768};
    int ty[10] = '{400, 600, 100, 21, 22, -23, 24, -25, 26, 32767};
    int ta[10] = '{5300, 12000, -20000, 9000, -9000, -18000, 32767, -32768, 18000, 17000};

    initial begin
        int n0;
        bit seen;
        int sx, sy, sa, sf;

        #23;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_y", int'(y_out), 0);
        check("rst_a", int'(angle_out), 0);
        check("rst_f", int'(flip_out), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) send(tx[i], ty[i], ta[i]);
        for (int i = 0; i < 16; i++)
            send(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768);
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);

        // Backpressure: output must sit still and new inputs must be ignored.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(123, -456, 25000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("bp_valid", int'(seen), 1);
        sx = int'(x_out); sy = int'(y_out); sa = int'(angle_out); sf = int'(flip_out);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; x_in = 7; y_in = 8; angle_in = 9;
            @(negedge clk);
            check("bp_x", int'(x_out), sx);
            check("bp_y", int'(y_out), sy);
            check("bp_a", int'(angle_out), sa);
            check("bp_f", int'(flip_out), sf);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = n_xfer;
        repeat (8) @(negedge clk);
        check("bp_xfers", n_xfer - n0, 1);
        check("bp_sb_empty", sb.size(), 0);

        // Reset while the sample sits in FOLD.
        @(posedge clk);
        #1;
        x_in = 500; y_in = -700; angle_in = 4000; in_valid = 1'b1;
        @(negedge clk);
        check("fr_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("fr_out_valid", int'(out_valid), 0);
        check("fr_x", int'(x_out), 0);
        check("fr_y", int'(y_out), 0);
        check("fr_a", int'(angle_out), 0);
        check("fr_f", int'(flip_out), 0);
        check("fr_in_ready_rst", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        n0 = n_xfer;
        repeat (8) @(negedge clk);
        check("fr_no_output", n_xfer - n0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
